// File: rtl/awgn_pkg.sv
// Shared types and width helpers for the AWGN statistics sink.
package awgn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DW_DEFAULT = 16;

  // Signed sum of 2^(log2n+1) samples needs log2n+1 extra bits.
  function automatic int sumw(input int dw, input int log2n);
    return dw + log2n + 1;
  endfunction

  // Each square is at most 2^(2*dw-2), so 2^(log2n+1) of them fit here.
  function automatic int sqw(input int dw, input int log2n);
    return 2 * dw + log2n;
  endfunction

endpackage

// File: rtl/awgn_stats_sq.sv
// Stage-2 square and magnitude of one signed sample, registered.
module awgn_stats_sq
  import awgn_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x,
  output logic [2*DW-1:0]      sq,
  output logic [DW-1:0]        mag
);

  logic signed [2*DW-1:0] x_ext;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]          abs_x;

  assign x_ext = {{DW{x[DW-1]}}, x};
  assign prod  = x_ext * x_ext;
  // The most negative value maps to 2^(DW-1), which is representable unsigned.
  assign abs_x = x[DW-1] ? (~x + 1'b1) : x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq  <= '0;
      mag <= '0;
    end else begin
      sq  <= prod;
      mag <= abs_x;
    end
  end

endmodule

// File: rtl/awgn_stats.sv
// Window statistics (mean, mean-square, peak |x|) over 2^LOG2N sample pairs.
module awgn_stats
  import awgn_pkg::*;
#(
  parameter int LOG2N = 10,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v,
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] x1,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] mean,
  output logic [2*DW-1:0]      meansq,
  output logic [DW-1:0]        peak
);

  localparam int SUMW  = sumw(DW, LOG2N);
  localparam int SQW   = sqw(DW, LOG2N);
  localparam int NPAIR = 1 << LOG2N;
  localparam int SH    = LOG2N + 1;
  localparam logic [LOG2N:0] LAST_CNT = (LOG2N + 1)'(NPAIR - 1);

  state_t state_q, state_d;
  logic   accept, launch;

  logic [LOG2N:0] cnt_q;
  logic           drain_q;

  logic signed [DW-1:0] x0_s1, x1_s1, x0_s2, x1_s2;
  logic                 vld_s1, vld_s2;
  logic [2*DW-1:0]      sq0, sq1;
  logic [DW-1:0]        mag0, mag1;

  logic signed [SUMW-1:0] sum_q;
  logic [SQW-1:0]         sqsum_q;
  logic [DW-1:0]          peak_q, peak_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        accept = v;
        if (v && cnt_q == LAST_CNT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);

  awgn_stats_sq #(.DW(DW)) u_sq0 (.clk(clk), .reset(reset), .x(x0_s1), .sq(sq0), .mag(mag0));
  awgn_stats_sq #(.DW(DW)) u_sq1 (.clk(clk), .reset(reset), .x(x1_s1), .sq(sq1), .mag(mag1));

  always_comb begin
    peak_nxt = peak_q;
    if (mag0 > peak_nxt) peak_nxt = mag0;
    if (mag1 > peak_nxt) peak_nxt = mag1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
      x0_s1   <= '0;
      x1_s1   <= '0;
      vld_s1  <= 1'b0;
      x0_s2   <= '0;
      x1_s2   <= '0;
      vld_s2  <= 1'b0;
      sum_q   <= '0;
      sqsum_q <= '0;
      peak_q  <= '0;
      done    <= 1'b0;
      mean    <= '0;
      meansq  <= '0;
      peak    <= '0;
    end else begin
      drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;

      x0_s1  <= x0;
      x1_s1  <= x1;
      vld_s1 <= accept;
      x0_s2  <= x0_s1;
      x1_s2  <= x1_s1;
      vld_s2 <= vld_s1;

      // The pipeline is empty whenever a launch can happen, so clear wins outright.
      if (launch) begin
        cnt_q   <= '0;
        sum_q   <= '0;
        sqsum_q <= '0;
        peak_q  <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + 1'b1;
        if (vld_s2) begin
          sum_q   <= sum_q + SUMW'(x0_s2) + SUMW'(x1_s2);
          sqsum_q <= sqsum_q + SQW'(sq0) + SQW'(sq1);
          peak_q  <= peak_nxt;
        end
      end

      done <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        mean   <= DW'(sum_q >>> SH);
        meansq <= (2 * DW)'(sqsum_q >> SH);
        peak   <= peak_q;
      end
    end
  end

endmodule

// File: tb/tb_awgn_stats.sv
// Directed scoreboard bench for awgn_stats with a 4-pair window.
module tb_awgn_stats;

  localparam int LOG2N = 2;
  localparam int DW    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x0 = '0;
  logic [15:0] x1 = '0;
  logic        busy, done;
  logic [15:0] mean;
  logic [31:0] meansq;
  logic [15:0] peak;

  awgn_stats #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .v(v), .x0(x0), .x1(x1), .start(start),
    .busy(busy), .done(done), .mean(mean), .meansq(meansq), .peak(peak)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] mean;
    logic [31:0] meansq;
    logic [15:0] peak;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        check("done_unexpected", {63'd0, done}, 64'd0);
      end else begin
        e = q.pop_front();
        check("mean", {48'd0, mean}, {48'd0, e.mean});
        check("meansq", {32'd0, meansq}, {32'd0, e.meansq});
        check("peak", {48'd0, peak}, {48'd0, e.peak});
        check("done_cycle", {32'd0, cyc}, {32'd0, e.at});
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int a, input int b);
    x0 = 16'(a);
    x1 = 16'(b);
  endtask

  task automatic push(input logic [15:0] m, input logic [31:0] ms, input logic [15:0] p,
                      input int unsigned at);
    exp_t e;
    e.mean = m; e.meansq = ms; e.peak = p; e.at = at;
    q.push_back(e);
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      check("timeout_pending", 64'(q.size()), 64'd0);
      q.delete();
    end
    step();
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_mean"}, {48'd0, mean}, 64'd0);
    check({tag, "_meansq"}, {32'd0, meansq}, 64'd0);
    check({tag, "_peak"}, {48'd0, peak}, 64'd0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    #2 reset = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int unsigned t;
  int pat[7] = '{1, 0, 1, 1, 0, 0, 1};

  initial begin
    #1 check_zero("por");
    step();
    step();
    reset = 1'b0;
    step();

    // 100 / -100: mean 0, meansq 10000, peak 100; v during the start edge is ignored
    set_x(100, -100);
    v = 1'b1; start = 1'b1;
    step(); t = cyc; start = 1'b0;
    push(16'd0, 32'd10000, 16'd100, t + 7);
    repeat (4) step();
    v = 1'b0;
    drain_wait();

    // asynchronous mid-cycle reset clears the nonzero results at once
    async_reset("rst_mid");

    // gapped v: accepts at t+1,t+3,t+4,t+7
    set_x(8, 8);
    v = 1'b0; start = 1'b1;
    step(); t = cyc; start = 1'b0;
    push(16'd8, 32'd64, 16'd8, t + 10);
    for (int i = 0; i < 7; i++) begin
      v = pat[i][0];
      step();
    end
    v = 1'b0;
    drain_wait();

    // most negative input, no wrap
    set_x(-32768, -32768);
    v = 1'b1; start = 1'b1;
    step(); t = cyc; start = 1'b0;
    push(16'h8000, 32'h4000_0000, 16'h8000, t + 7);
    repeat (4) step();
    v = 1'b0;
    drain_wait();

    // start pulses in RUN, DRAIN and DONE are ignored: single done
    set_x(3, 5);
    v = 1'b1; start = 1'b1;
    step(); t = cyc; start = 1'b0;
    push(16'd4, 32'd17, 16'd5, t + 7);
    step();
    start = 1'b1; step();
    start = 1'b0; step(); step();
    start = 1'b1; step(); step(); step();
    start = 1'b0; v = 1'b0;
    drain_wait();

    // reset during RUN, then verify it stays idle with zero results
    set_x(1000, 1000);
    v = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    async_reset("rst_run");
    step();
    check_zero("post_rst");

    // truncating shift of a negative sum, start held high relaunches after DONE
    set_x(-7, 2);
    v = 1'b1; start = 1'b1;
    step(); t = cyc;
    push(16'hfffd, 32'd26, 16'd7, t + 7);
    push(16'hfffd, 32'd26, 16'd7, t + 15);
    repeat (8) step();
    start = 1'b0;
    drain_wait();
    v = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
